// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFFlush,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pcplus4,
  output logic        IFID_valid,
  output logic [15:0] stall_cycles
);

  logic [31:0] pcplus4;
  logic [31:0] next_pc;

  // The kernel bit never changes on sequential fetch; only the low 31 bits wrap.
  assign pcplus4   = {pc[31], pc[30:0] + 31'd4};
  // Memory address comes straight from the PC register, so it only moves on clock edges.
  assign imem_addr = pc;

  // Next-PC selection; unused encodings fall back to sequential fetch.
  always_comb begin
    next_pc = pcplus4;
    case (pcsrc)
      3'b001:  next_pc = branch_taken ? branch_target : pcplus4;
      3'b010:  next_pc = jump_target;
      3'b011:  next_pc = jr_target;
      3'b100:  next_pc = ILLOP_PC;
      3'b101:  next_pc = XADR_PC;
      default: next_pc = pcplus4;
    endcase
  end

  // PC, IF/ID register and stall counter; a flush wins over both load and hold of IF/ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      IFID_instr   <= 32'd0;
      IFID_pcplus4 <= 32'd0;
      IFID_valid   <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      if (PCWrite) begin
        pc <= next_pc;
      end

      if (IFFlush) begin
        IFID_instr   <= 32'd0;
        IFID_pcplus4 <= 32'd0;
        IFID_valid   <= 1'b0;
      end else if (PCWrite) begin
        IFID_instr   <= imem_rdata;
        IFID_pcplus4 <= pcplus4;
        IFID_valid   <= 1'b1;
      end

      if (!PCWrite && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IFFlush;
  logic [2:0]  pcsrc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pcplus4;
  logic        IFID_valid;
  logic [15:0] stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Instruction memory: each word is its own address tagged, so the bench can predict it.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign imem_rdata = tag(imem_addr);

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IFFlush      (IFFlush),
    .pcsrc        (pcsrc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .jr_target    (jr_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .IFID_instr   (IFID_instr),
    .IFID_pcplus4 (IFID_pcplus4),
    .IFID_valid   (IFID_valid),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic        rst;
    logic        pw;
    logic        fl;
    logic [2:0]  src;
    logic        bt;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic [31:0] jrtgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_v;
    logic [15:0] e_sc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic vec_t mkv(input logic rst, input logic pw, input logic fl,
                               input logic [2:0] src, input logic bt,
                               input logic [31:0] btgt, input logic [31:0] jtgt,
                               input logic [31:0] jrtgt, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic [31:0] e_p4,
                               input logic e_v, input logic [15:0] e_sc);
    vec_t v;
    v.rst = rst; v.pw = pw; v.fl = fl; v.src = src; v.bt = bt;
    v.btgt = btgt; v.jtgt = jtgt; v.jrtgt = jrtgt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_p4 = e_p4; v.e_v = e_v; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s [%0d] got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic check_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_p4, input logic e_v, input logic [15:0] e_sc);
    check("pc", idx, pc, e_pc);
    check("imem_addr", idx, imem_addr, e_pc);
    check("IFID_instr", idx, IFID_instr, e_instr);
    check("IFID_pcplus4", idx, IFID_pcplus4, e_p4);
    check("IFID_valid", idx, {31'd0, IFID_valid}, {31'd0, e_v});
    check("stall_cycles", idx, {16'd0, stall_cycles}, {16'd0, e_sc});
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    PCWrite       = v.pw;
    IFFlush       = v.fl;
    pcsrc         = v.src;
    branch_taken  = v.bt;
    branch_target = v.btgt;
    jump_target   = v.jtgt;
    jr_target     = v.jrtgt;
  endtask

  initial begin
    // rst pw fl src bt btgt jtgt jrtgt | pc instr pcplus4 valid stall
    vecs[0]  = mkv(1, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 16'd0);
    vecs[1]  = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0004, tag(32'h8000_0000), 32'h8000_0004, 1, 16'd0);
    vecs[2]  = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0008, tag(32'h8000_0004), 32'h8000_0008, 1, 16'd0);
    vecs[3]  = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_000C, tag(32'h8000_0008), 32'h8000_000C, 1, 16'd0);
    vecs[4]  = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0010, tag(32'h8000_000C), 32'h8000_0010, 1, 16'd0);
    // load-use bubble, then refetch of the same PC
    vecs[5]  = mkv(0, 0, 1, 3'b000, 0, 0, 0, 0, 32'h8000_0010, 32'h0, 32'h0, 0, 16'd1);
    vecs[6]  = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0014, tag(32'h8000_0010), 32'h8000_0014, 1, 16'd1);
    // plain stall with a jump presented that must be ignored
    vecs[7]  = mkv(0, 0, 0, 3'b010, 0, 0, 32'hDEAD_0000, 0, 32'h8000_0014, tag(32'h8000_0010), 32'h8000_0014, 1, 16'd2);
    vecs[8]  = mkv(0, 0, 0, 3'b010, 0, 0, 32'hDEAD_0000, 0, 32'h8000_0014, tag(32'h8000_0010), 32'h8000_0014, 1, 16'd3);
    // redirects
    vecs[9]  = mkv(0, 1, 0, 3'b001, 1, 32'h0000_0400, 0, 0, 32'h0000_0400, tag(32'h8000_0014), 32'h8000_0018, 1, 16'd3);
    vecs[10] = mkv(0, 1, 0, 3'b001, 0, 32'h0000_0800, 0, 0, 32'h0000_0404, tag(32'h0000_0400), 32'h0000_0404, 1, 16'd3);
    vecs[11] = mkv(0, 1, 0, 3'b011, 0, 0, 0, 32'h0000_1000, 32'h0000_1000, tag(32'h0000_0404), 32'h0000_0408, 1, 16'd3);
    vecs[12] = mkv(0, 1, 0, 3'b101, 0, 0, 0, 0, 32'h8000_0008, tag(32'h0000_1000), 32'h0000_1004, 1, 16'd3);
    vecs[13] = mkv(0, 1, 0, 3'b111, 0, 0, 0, 0, 32'h8000_000C, tag(32'h8000_0008), 32'h8000_000C, 1, 16'd3);
    vecs[14] = mkv(0, 1, 1, 3'b100, 0, 0, 0, 0, 32'h8000_0004, 32'h0, 32'h0, 0, 16'd3);
    vecs[15] = mkv(0, 1, 0, 3'b010, 0, 0, 32'h0000_2000, 0, 32'h0000_2000, tag(32'h8000_0004), 32'h8000_0008, 1, 16'd3);
    // PC wrap in both halves of the address space
    vecs[16] = mkv(0, 1, 0, 3'b011, 0, 0, 0, 32'h7FFF_FFFC, 32'h7FFF_FFFC, tag(32'h0000_2000), 32'h0000_2004, 1, 16'd3);
    vecs[17] = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h0000_0000, tag(32'h7FFF_FFFC), 32'h0000_0000, 1, 16'd3);
    vecs[18] = mkv(0, 1, 0, 3'b010, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, tag(32'h0000_0000), 32'h0000_0004, 1, 16'd3);
    vecs[19] = mkv(0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h8000_0000, tag(32'hFFFF_FFFC), 32'h8000_0000, 1, 16'd3);
    // taken branch while stalled is ignored
    vecs[20] = mkv(0, 0, 0, 3'b001, 1, 32'h0000_0400, 0, 0, 32'h8000_0000, tag(32'hFFFF_FFFC), 32'h8000_0000, 1, 16'd4);
    // reset mid-run clears everything
    vecs[21] = mkv(1, 1, 0, 3'b010, 0, 0, 32'h0000_3000, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 16'd0);

    drive(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p4, vecs[i].e_v, vecs[i].e_sc);
    end

    // Long stall with a pending jump: counter must saturate, PC must not move.
    reset = 1'b0; PCWrite = 1'b0; IFFlush = 1'b0; pcsrc = 3'b010; jump_target = 32'h0000_3000;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    check("sat_exact", 100, {16'd0, stall_cycles}, 32'h0000_FFFF);
    for (int i = 0; i < 4465; i++) @(posedge clk);
    #1;
    check("sat_hold", 101, {16'd0, stall_cycles}, 32'h0000_FFFF);
    check("stall_pc", 102, pc, 32'h8000_0000);
    check("stall_valid", 103, {31'd0, IFID_valid}, 32'd0);

    // Control inputs must not reach imem_addr between edges.
    PCWrite = 1'b1; pcsrc = 3'b010; jump_target = 32'h0000_5000;
    #2;
    check("imem_comb", 104, imem_addr, 32'h8000_0000);

    // Reset beats the pending jump and the saturated counter.
    reset = 1'b1; PCWrite = 1'b0;
    @(posedge clk);
    #1;
    check_all(105, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'd0);

    // First fetch after reset release.
    reset = 1'b0; PCWrite = 1'b1; pcsrc = 3'b000;
    @(posedge clk);
    #1;
    check_all(106, 32'h8000_0004, tag(32'h8000_0000), 32'h8000_0004, 1'b1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the PC register, next-PC selection and the IF/ID pipeline register. It is the consumer of the hazard unit's `PCWrite` and `IFFlush` controls, turning them into held PCs, held IF/ID contents or inserted bubbles. It drives the instruction-memory address and presents the fetched instruction plus PC+4 to the ID stage.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value after reset (kernel mode, bit 31 set).
- `ILLOP_PC`, 32'h8000_0004, target for `pcsrc`=3'b100.
- `XADR_PC`, 32'h8000_0008, target for `pcsrc`=3'b101.

Ports:
- `clk` in 1, single clock; all state updates on rising edge.
- `reset` in 1, synchronous, active-high.
- `PCWrite` in 1, 1 = PC may update this cycle; 0 = PC holds.
- `IFFlush` in 1, 1 = load bubble into IF/ID this cycle.
- `pcsrc` in 3, next-PC select from ID: 000 seq, 001 branch, 010 J/JAL, 011 JR/JALR, 100 ILLOP, 101 XADR, 110/111 treated as 000.
- `branch_taken` in 1, qualifies `pcsrc`=001.
- `branch_target` in 32, taken-branch target.
- `jump_target` in 32, fully formed J/JAL target.
- `jr_target` in 32, register value for JR/JALR.
- `imem_addr` out 32, equals `pc` combinationally.
- `imem_rdata` in 32, instruction at `imem_addr`, combinational read, same cycle.
- `pc` out 32, current PC register.
- `IFID_instr` out 32, registered instruction to ID.
- `IFID_pcplus4` out 32, registered PC+4 of that instruction.
- `IFID_valid` out 1, 0 = bubble.
- `stall_cycles` out 16, saturating count of cycles with `PCWrite`=0.

## Operation
- `pcplus4` = {pc[31], pc[30:0] + 4}; low 31 bits wrap modulo 2^31, bit 31 (kernel bit) preserved.
- Next PC: 001 & `branch_taken` → `branch_target`; 001 & !`branch_taken` → `pcplus4`; 010 → `jump_target`; 011 → `jr_target` (bit 31 taken as-is, so JR can leave kernel mode); 100 → `ILLOP_PC`; 101 → `XADR_PC`; 000/110/111 → `pcplus4`.
- Control combinations (evaluated each edge, reset excluded):
  - `PCWrite`=1, `IFFlush`=0: PC ← next PC; IF/ID ← {`imem_rdata`, `pcplus4`, valid=1}.
  - `PCWrite`=0, `IFFlush`=0: PC holds; IF/ID holds all fields.
  - `PCWrite`=0, `IFFlush`=1: PC holds; IF/ID ← bubble. Same PC refetched next cycle (load-use / branch-operand stall scheme).
  - `PCWrite`=1, `IFFlush`=1: PC ← next PC; IF/ID ← bubble (redirect squash, e.g. jump in EX).
- Bubble = `IFID_instr`=0 (sll $0,$0,0), `IFID_pcplus4`=0, `IFID_valid`=0.
- `pcsrc`/targets are ignored whenever `PCWrite`=0; redirect is not latched, ID must re-present it.
- `stall_cycles` += 1 on each non-reset edge with `PCWrite`=0; holds at 16'hFFFF.

## Timing
- Reset values: `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `IFID_instr`=0, `IFID_pcplus4`=0, `IFID_valid`=0, `stall_cycles`=0.
- Reset has priority over every input on the edge it is sampled; asserted mid-stall or mid-redirect, the pending redirect is discarded.
- First instruction appears at IF/ID one edge after `reset` deasserts, with `IFID_pcplus4`=`RESET_PC`+4.
- Redirect latency: target becomes `pc` on the edge where `PCWrite`=1 and `pcsrc` selects it; its instruction reaches IF/ID one edge later.
- `imem_addr` changes only at clock edges (no combinational path from control inputs).
- Counter saturation and PC wrap are independent; PC at 32'h7FFF_FFFC seq → 32'h0000_0000; 32'hFFFF_FFFC → 32'h8000_0000.

## Test plan
- Reset then 3 free-running cycles, imem returns addr-tagged words → `pc` 8000_0000/…04/…08/…0C, `IFID_pcplus4` 8000_0004 then …08, `IFID_valid`=1 after first edge.
- Load-use: hold `PCWrite`=0, `IFFlush`=1 one cycle at pc=8000_0010 → pc stays 8000_0010, IF/ID bubble (instr 0, valid 0), next edge IF/ID gets instr@8000_0010, `stall_cycles`=1.
- Plain stall `PCWrite`=0, `IFFlush`=0 for 2 cycles → pc and all IF/ID fields unchanged, `stall_cycles`=2.
- Redirects: `pcsrc`=001 taken target 0000_0400 → pc=0000_0400; 001 not-taken → pc+4; 011 jr 0000_1000 → pc=0000_1000 (kernel bit cleared); 101 → 8000_0008; 111 → pc+4; with `IFFlush`=1 IF/ID bubble same edge.
- Wrap: force pc 7FFF_FFFC seq → 0000_0000; pc FFFF_FFFC seq → 8000_0000.
- Reset asserted while `PCWrite`=0 and `pcsrc`=010 pending, and `stall_cycles` preloaded by 70000 stall cycles (reads FFFF) → next edge all reset values, `stall_cycles`=0.
